// File: rtl/vec_pkg.sv
`default_nettype none
// ============================================================================
// Module   : vec_pkg
// Purpose  : Shared types and constants for the vector execution unit:
//            element function encoding, op-field bit positions, FSM states
//            and a clog2 helper that never returns zero.
// Revision : 1.0 - initial release
// ============================================================================
package vec_pkg;

    // Element function, carried in op_i[1:0]
    typedef enum logic [1:0] {
        ADD = 2'b00,
        SUB = 2'b01,
        MUL = 2'b10,
        MIN = 2'b11
    } vec_func_e;

    // Control FSM states
    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EXEC = 2'b01,
        DONE = 2'b10
    } vec_state_e;

    // Op field positions
    localparam int OP_SAT_BIT    = 3;
    localparam int OP_SCALAR_BIT = 2;

    // clog2 that yields at least one bit, so single-entry counters stay legal
    function automatic int safe_clog2(input int x);
        return (x <= 1) ? 1 : $clog2(x);
    endfunction

endpackage : vec_pkg
`default_nettype wire

// File: rtl/vec_lane_alu.sv
`default_nettype none
// ============================================================================
// Module   : vec_lane_alu
// Purpose  : Combinational single-element unsigned ALU (add/sub/mul/min) with
//            optional saturation.
// Ports    : i_a, i_b  - unsigned operands (vdw_p bits)
//            i_func    - element function (vec_func_e encoding)
//            i_sat     - 1 = saturate, 0 = wrap (ignored for MIN)
//            o_res     - vdw_p-bit result
// Revision : 1.0 - initial release
// ============================================================================
module vec_lane_alu
    import vec_pkg::*;
#(
    parameter int vdw_p = 4
) (
    input  logic [vdw_p-1:0] i_a,
    input  logic [vdw_p-1:0] i_b,
    input  logic [1:0]       i_func,
    input  logic             i_sat,
    output logic [vdw_p-1:0] o_res
);

    logic [vdw_p:0]     w_sum;   // MSB is the carry-out
    logic [vdw_p:0]     w_diff;  // MSB is the borrow (a < b)
    logic [2*vdw_p-1:0] w_prod;

    assign w_sum  = {1'b0, i_a} + {1'b0, i_b};
    assign w_diff = {1'b0, i_a} - {1'b0, i_b};
    assign w_prod = {{vdw_p{1'b0}}, i_a} * {{vdw_p{1'b0}}, i_b};

    always_comb begin
        o_res = '0;
        case (vec_func_e'(i_func))
            ADD: o_res = (i_sat && w_sum[vdw_p])  ? '1 : w_sum[vdw_p-1:0];
            SUB: o_res = (i_sat && w_diff[vdw_p]) ? '0 : w_diff[vdw_p-1:0];
            MUL: o_res = (i_sat && (|w_prod[2*vdw_p-1:vdw_p])) ? '1 : w_prod[vdw_p-1:0];
            MIN: o_res = (i_a < i_b) ? i_a : i_b;
            default: o_res = '0;
        endcase
    end

endmodule : vec_lane_alu
`default_nettype wire

// File: rtl/vector_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : vector_exec_unit
// Purpose  : Multi-beat vector ALU. Latches a command, computes lanes_p
//            elements per cycle over beats_lp = vlen_p/lanes_p beats, then
//            holds the result until the consumer takes it.
// Ports    : clk_i, reset_i (sync, active high)
//            op_i      - [3] sat, [2] scalar broadcast, [1:0] function
//            a_i, b_i  - operand vectors (element e at [e*vdw_p +: vdw_p])
//            scalar_i  - broadcast B element in scalar mode
//            mask_i    - per-element compute enable (0 = pass A)
//            v_i/ready_o      - command handshake
//            data_o/v_o/yumi_i - result handshake
//            done_o    - one-cycle pulse on first result-valid cycle
// Revision : 1.0 - initial release
// ============================================================================
module vector_exec_unit
    import vec_pkg::*;
#(
    parameter int vlen_p  = 4,
    parameter int vdw_p   = 4,
    parameter int lanes_p = 2
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic [3:0]              op_i,
    input  logic [vlen_p*vdw_p-1:0] a_i,
    input  logic [vlen_p*vdw_p-1:0] b_i,
    input  logic [vdw_p-1:0]        scalar_i,
    input  logic [vlen_p-1:0]       mask_i,
    input  logic                    v_i,
    output logic                    ready_o,
    output logic [vlen_p*vdw_p-1:0] data_o,
    output logic                    v_o,
    input  logic                    yumi_i,
    output logic                    done_o
);

    localparam int c_BEATS = vlen_p / lanes_p;
    localparam int c_CNT_W = safe_clog2(c_BEATS);
    localparam int c_IDX_W = safe_clog2(vlen_p);
    localparam logic [c_CNT_W-1:0] c_LAST_BEAT = c_CNT_W'(c_BEATS - 1);

    // ------------------------------------------------------------------
    // State and operand/result registers
    // ------------------------------------------------------------------
    vec_state_e         r_state;
    vec_state_e         w_state_next;
    logic [c_CNT_W-1:0] r_cnt;
    logic [1:0]         r_func;
    logic               r_sat;
    logic [vlen_p-1:0]  r_mask;
    logic [vdw_p-1:0]   r_a   [vlen_p];
    logic [vdw_p-1:0]   r_b   [vlen_p];   // already holds the broadcast scalar in scalar mode
    logic [vdw_p-1:0]   r_res [vlen_p];
    logic               r_done;
    logic               w_done_next;
    logic               w_accept;
    logic               w_last;

    // Lane select / lane result
    logic [c_IDX_W-1:0] w_idx      [lanes_p];
    logic [vdw_p-1:0]   w_lane_a   [lanes_p];
    logic [vdw_p-1:0]   w_lane_b   [lanes_p];
    logic               w_lane_m   [lanes_p];
    logic [vdw_p-1:0]   w_lane_res [lanes_p];
    logic [vdw_p-1:0]   w_lane_out [lanes_p];

    assign w_accept = v_i & ready_o;
    assign w_last   = (r_cnt == c_LAST_BEAT);
    assign done_o   = r_done;

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state <= IDLE;
            r_done  <= 1'b0;
        end else begin
            r_state <= w_state_next;
            r_done  <= w_done_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_done_next  = 1'b0;
        ready_o      = 1'b0;
        v_o          = 1'b0;
        case (r_state)
            IDLE: begin
                ready_o = 1'b1;
                if (v_i) w_state_next = EXEC;
            end
            EXEC: begin
                if (w_last) begin
                    w_state_next = DONE;
                    w_done_next  = 1'b1;   // pulse lands on the DONE entry cycle
                end
            end
            DONE: begin
                v_o = 1'b1;
                if (yumi_i) w_state_next = IDLE;
            end
            default: w_state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Lane element select: beat cnt covers elements cnt*lanes_p + l
    // ------------------------------------------------------------------
    always_comb begin
        for (int l = 0; l < lanes_p; l++) begin
            w_idx[l]    = c_IDX_W'(int'(r_cnt) * lanes_p + l);
            w_lane_a[l] = r_a[w_idx[l]];
            w_lane_b[l] = r_b[w_idx[l]];
            w_lane_m[l] = r_mask[w_idx[l]];
        end
    end

    generate
        for (genvar l = 0; l < lanes_p; l++) begin : g_lane
            vec_lane_alu #(
                .vdw_p (vdw_p)
            ) u_alu (
                .i_a    (w_lane_a[l]),
                .i_b    (w_lane_b[l]),
                .i_func (r_func),
                .i_sat  (r_sat),
                .o_res  (w_lane_res[l])
            );
            // Masked-off elements pass operand A through unchanged
            assign w_lane_out[l] = w_lane_m[l] ? w_lane_res[l] : w_lane_a[l];
        end
    endgenerate

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_cnt  <= '0;
            r_func <= '0;
            r_sat  <= 1'b0;
            r_mask <= '0;
            for (int e = 0; e < vlen_p; e++) begin
                r_a[e]   <= '0;
                r_b[e]   <= '0;
                r_res[e] <= '0;
            end
        end else if (w_accept) begin
            r_cnt  <= '0;
            r_func <= op_i[1:0];
            r_sat  <= op_i[OP_SAT_BIT];
            r_mask <= mask_i;
            for (int e = 0; e < vlen_p; e++) begin
                r_a[e] <= a_i[e*vdw_p +: vdw_p];
                r_b[e] <= op_i[OP_SCALAR_BIT] ? scalar_i : b_i[e*vdw_p +: vdw_p];
            end
        end else if (r_state == EXEC) begin
            r_cnt <= r_cnt + c_CNT_W'(1);
            for (int l = 0; l < lanes_p; l++) begin
                r_res[w_idx[l]] <= w_lane_out[l];
            end
        end
    end

    always_comb begin
        data_o = '0;
        for (int e = 0; e < vlen_p; e++) begin
            data_o[e*vdw_p +: vdw_p] = r_res[e];
        end
    end

endmodule : vector_exec_unit
`default_nettype wire

// File: tb/tb_vector_exec_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_vector_exec_unit
// Purpose  : Self-checking bench for vector_exec_unit (vlen 4, 4-bit, 2 lanes).
//            Directed vectors plus randomized commands checked against an
//            element-wise arithmetic reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_vector_exec_unit;

    localparam int VLEN  = 4;
    localparam int VDW   = 4;
    localparam int LANES = 2;
    localparam int BEATS = VLEN / LANES;
    localparam int MAXV  = (1 << VDW) - 1;

    logic                 clk = 1'b0;
    logic                 reset_i;
    logic [3:0]           op_i;
    logic [VLEN*VDW-1:0]  a_i;
    logic [VLEN*VDW-1:0]  b_i;
    logic [VDW-1:0]       scalar_i;
    logic [VLEN-1:0]      mask_i;
    logic                 v_i;
    logic                 ready_o;
    logic [VLEN*VDW-1:0]  data_o;
    logic                 v_o;
    logic                 yumi_i;
    logic                 done_o;

    int checks = 0;
    int errors = 0;

    vector_exec_unit #(
        .vlen_p  (VLEN),
        .vdw_p   (VDW),
        .lanes_p (LANES)
    ) dut (
        .clk_i    (clk),
        .reset_i  (reset_i),
        .op_i     (op_i),
        .a_i      (a_i),
        .b_i      (b_i),
        .scalar_i (scalar_i),
        .mask_i   (mask_i),
        .v_i      (v_i),
        .ready_o  (ready_o),
        .data_o   (data_o),
        .v_o      (v_o),
        .yumi_i   (yumi_i),
        .done_o   (done_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference: element-wise unsigned arithmetic on plain integers
    function automatic logic [15:0] model(input logic [3:0] op, input logic [15:0] a,
                                          input logic [15:0] b, input logic [3:0] sc,
                                          input logic [3:0] mask);
        logic [15:0] res;
        int av, bv, r;
        res = '0;
        for (int e = 0; e < VLEN; e++) begin
            av = int'(a[e*VDW +: VDW]);
            bv = op[2] ? int'(sc) : int'(b[e*VDW +: VDW]);
            if (!mask[e]) begin
                r = av;
            end else begin
                case (op[1:0])
                    2'd0: begin r = av + bv; if (r > MAXV) r = op[3] ? MAXV : r - (MAXV + 1); end
                    2'd1: begin r = av - bv; if (r < 0)    r = op[3] ? 0    : r + (MAXV + 1); end
                    2'd2: begin r = av * bv; if (r > MAXV) r = op[3] ? MAXV : r % (MAXV + 1); end
                    default: r = (av < bv) ? av : bv;
                endcase
            end
            res[e*VDW +: VDW] = r[VDW-1:0];
        end
        return res;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue a command, wait for the result with a bounded budget, check
    // latency/done/data, then retire it with yumi.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [15:0] a,
                          input logic [15:0] b, input logic [3:0] sc, input logic [3:0] mask,
                          input logic [15:0] exp);
        int lat;
        check({tag, ":ready"}, 32'(ready_o), 32'd1);
        op_i = op; a_i = a; b_i = b; scalar_i = sc; mask_i = mask; v_i = 1'b1;
        tick();
        // Scramble inputs after accept; the latched command must not change
        v_i = 1'b0;
        op_i = 4'($urandom); a_i = 16'($urandom); b_i = 16'($urandom);
        scalar_i = 4'($urandom); mask_i = 4'($urandom);
        lat = 0;
        while (!v_o && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, ":latency"}, 32'(lat), 32'(BEATS));
        check({tag, ":done"}, 32'(done_o), 32'd1);
        check({tag, ":data"}, 32'(data_o), 32'(exp));
        tick();
        check({tag, ":done_off"}, 32'(done_o), 32'd0);
        check({tag, ":hold"}, 32'(data_o), 32'(exp));
        yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        check({tag, ":idle"}, {30'd0, ready_o, v_o}, 32'b10);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0]  rop;
        logic [15:0] ra, rb, snap;
        logic [3:0]  rsc, rmask;

        reset_i = 1'b1; op_i = '0; a_i = '0; b_i = '0; scalar_i = '0;
        mask_i = '0; v_i = 1'b0; yumi_i = 1'b0;
        tick(); tick();
        reset_i = 1'b0;
        check("reset:ready", 32'(ready_o), 32'd1);
        check("reset:v_o",   32'(v_o),     32'd0);
        check("reset:done",  32'(done_o),  32'd0);
        check("reset:data",  32'(data_o),  32'd0);

        // Directed vectors
        run_op("add_vv",   4'b0000, 16'h0101, 16'h1144, 4'h0, 4'hF,    16'h1245);
        run_op("sub_wrap", 4'b0001, 16'h0101, 16'h1144, 4'h0, 4'hF,    16'hF0CD);
        run_op("sub_sat",  4'b1001, 16'h0101, 16'h1144, 4'h0, 4'hF,    16'h0000);
        run_op("mul_sw",   4'b0110, 16'h5678, 16'hABCD, 4'h3, 4'hF,    16'hF258);
        run_op("mul_ss",   4'b1110, 16'h5678, 16'hABCD, 4'h3, 4'hF,    16'hFFFF);
        run_op("mul_sw2",  4'b0110, 16'h1234, 16'h0000, 4'h3, 4'hF,    16'h369C);
        run_op("mul_ss2",  4'b1110, 16'h1234, 16'h0000, 4'h3, 4'hF,    16'h369C);
        run_op("min_vv",   4'b1011, 16'h1928, 16'h8383, 4'h0, 4'hF,    16'h1323);
        run_op("add_mask", 4'b0000, 16'h1111, 16'h2222, 4'h0, 4'b0101, 16'h1313);
        run_op("add_sat",  4'b1000, 16'hF9F1, 16'h1718, 4'h0, 4'hF,    16'hFFF9);

        // Backpressure: hold result with v_i toggling
        op_i = 4'b0000; a_i = 16'h0101; b_i = 16'h1144; mask_i = 4'hF; v_i = 1'b1;
        tick();
        v_i = 1'b0;
        for (int i = 0; i < 20 && !v_o; i++) tick();
        check("bp:first_v", 32'(v_o), 32'd1);
        snap = 16'h1245;
        for (int i = 0; i < 5; i++) begin
            v_i = ~v_i; a_i = 16'($urandom); op_i = 4'($urandom);
            tick();
            check("bp:v_o",   32'(v_o),    32'd1);
            check("bp:ready", 32'(ready_o), 32'd0);
            check("bp:done",  32'(done_o), 32'd0);
            check("bp:data",  32'(data_o), 32'(snap));
        end
        v_i = 1'b0; yumi_i = 1'b1;
        tick();
        yumi_i = 1'b0;
        check("bp:release", {30'd0, ready_o, v_o}, 32'b10);

        // Reset during EXEC beat 0
        op_i = 4'b0000; a_i = 16'h1111; b_i = 16'h2222; mask_i = 4'hF; v_i = 1'b1;
        tick();
        v_i = 1'b0; reset_i = 1'b1;
        tick();
        reset_i = 1'b0;
        check("rst_exec:ready", 32'(ready_o), 32'd1);
        check("rst_exec:v_o",   32'(v_o),     32'd0);
        check("rst_exec:data",  32'(data_o),  32'd0);
        check("rst_exec:done",  32'(done_o),  32'd0);
        run_op("post_rst", 4'b0000, 16'h0101, 16'h1144, 4'h0, 4'hF, 16'h1245);

        // Randomized commands against the reference model
        for (int i = 0; i < 24; i++) begin
            rop = 4'($urandom); ra = 16'($urandom); rb = 16'($urandom);
            rsc = 4'($urandom); rmask = 4'($urandom);
            run_op("rand", rop, ra, rb, rsc, rmask, model(rop, ra, rb, rsc, rmask));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_vector_exec_unit
`default_nettype wire
